fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter FFT_MEM_SIZE, default 1024, SHALL set the frame length in samples (power of two, 8 to 4096).
REQ-002 Parameter ADDR_WDT, default $clog2(FFT_MEM_SIZE), SHALL set the memory address width.
REQ-003 Port clk, input, 1: the single clock. All logic SHALL be rising-edge clocked.
REQ-004 Port rst_n, input, 1: reset. SHALL be asynchronous assert and active-low.
REQ-005 Port s_axis_tvalid / s_axis_tlast, input, 1 each: input-frame AXIS handshake and frame marker.
REQ-006 Port s_axis_tready, output, 1: ready for the input frame.
REQ-007 Port mem_wr_en / mem_wr_addr, output, 1 / ADDR_WDT: sample write strobe and address.
REQ-008 Port fft_start, output, 1: one-cycle compute trigger to the FFT core.
REQ-009 Port fft_done, input, 1: one-cycle compute-complete pulse from the FFT core.
REQ-010 Port mem_rd_en / mem_rd_addr, output, 1 / ADDR_WDT: result read strobe and address. Read data is registered, returns 1 cycle later, and holds while mem_rd_en is low.
REQ-011 Port m_axis_tvalid / m_axis_tlast, output, 1 each: output AXIS valid and frame marker.
REQ-012 Port m_axis_tready, input, 1: downstream ready.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port err_tlast, output, 1: sticky framing error flag.
REQ-015 Port clr_err, input, 1: synchronous clear of err_tlast.
REQ-016 Port frame_cnt, output, 16: count of completed frames. Wraps from 0xFFFF to 0.

Function
REQ-017 States SHALL be IDLE, LOAD, COMPUTE, UNLOAD.
REQ-018 IDLE -> LOAD SHALL occur unconditionally on the first clock after reset.
REQ-019 LOAD behaviour:
- s_axis_tready = 1.
- Each cycle with s_axis_tvalid && s_axis_tready, mem_wr_en = 1 combinationally and mem_wr_addr = wr_cnt; wr_cnt then increments.
REQ-020 Leaving LOAD: on the handshake with wr_cnt = FFT_MEM_SIZE-1, the state SHALL go to COMPUTE and fft_start SHALL pulse on the following cycle.
REQ-021 Early tlast (tlast on a beat with wr_cnt < FFT_MEM_SIZE-1): err_tlast SHALL set, wr_cnt SHALL return to 0, and the state SHALL stay LOAD (partial frame discarded).
REQ-022 Missing tlast on the final beat: err_tlast SHALL set and the frame SHALL still proceed to COMPUTE.
REQ-023 COMPUTE behaviour:
- s_axis_tready = 0, and no memory strobes are issued.
- On fft_done the state goes to UNLOAD.
- fft_done in any other state SHALL be ignored.
REQ-024 UNLOAD read issue: mem_rd_en = 1 when rd_cnt < FFT_MEM_SIZE && (!m_axis_tvalid || m_axis_tready), with mem_rd_addr = rd_cnt; rd_cnt increments on each issue.
REQ-025 UNLOAD output valid: m_axis_tvalid SHALL be registered. It sets the cycle after an issue and clears on a tready handshake with no new issue. Read-to-valid latency is 1 cycle, and full throughput is 1 beat/cycle when tready is held high.
REQ-026 m_axis_tvalid, once high, SHALL NOT drop without a handshake. m_axis_tlast SHALL be high exactly with the beat from address FFT_MEM_SIZE-1.
REQ-027 End of UNLOAD: on the tlast handshake, frame_cnt increments and the state returns to LOAD with wr_cnt = rd_cnt = 0. Input and output are not overlapped.
REQ-028 When clr_err and a new error occur in the same cycle, the error SHALL win.

Reset
REQ-029 While rst_n = 0, the block SHALL hold:
- state = IDLE;
- wr_cnt, rd_cnt, frame_cnt = 0;
- s_axis_tready, mem_wr_en, mem_rd_en, fft_start, m_axis_tvalid, m_axis_tlast, busy, err_tlast = 0.
REQ-030 Reset asserted mid-LOAD, mid-COMPUTE or mid-UNLOAD SHALL abandon the frame. After release, the block SHALL restart with an empty frame and ignore a pending fft_done.

Structure
REQ-031 The state enum type fft_ctrl_state_t and the FFT_MEM_SIZE default SHALL live in sim_pckg-compatible shared package fft_ctrl_pckg.
REQ-032 The output valid/tlast register pipeline SHALL be one sub-module, fft_rd_stage. All other logic SHALL be flat.

Verification
REQ-033 Nominal frame: 1024 beats with tlast on beat 1023 and tready=1; then fft_done after 50 cycles. Required:
- 1024 mem_wr_en pulses at addresses 0..1023 and one fft_start;
- 1024 output beats on consecutive cycles, tlast on beat 1023;
- frame_cnt = 1.
REQ-034 Backpressure: m_axis_tready toggles 1,0,0,1 repeating. Required: no beat lost or duplicated, addresses in order 0..1023, and tvalid never drops without a handshake.
REQ-035 Early tlast on beat 10. Required: err_tlast = 1; the next 1024 beats load at addresses 0..1023; clr_err clears the flag.
REQ-036 Spurious fft_done during LOAD. Required: ignored, no state change.
REQ-037 Reset at UNLOAD beat 500. Required: all outputs 0 during reset, frame_cnt = 0, and a fresh load starts at address 0 after release.
REQ-038 frame_cnt preloaded to 0xFFFF by force, then one frame completes. Required: frame_cnt wraps to 0.

Source files
------------

// File: rtl/fft_ctrl_pckg.sv
// Shared types and defaults for the FFT frame controller.
package fft_ctrl_pckg;

  localparam int unsigned FFT_MEM_SIZE_DFLT = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    UNLOAD  = 2'd3
  } fft_ctrl_state_t;

endpackage

// File: rtl/fft_rd_stage.sv
// Output valid/last register stage that sits behind the registered result memory read.
module fft_rd_stage #(
  parameter int unsigned FFT_MEM_SIZE = 1024,
  parameter int unsigned ADDR_WDT     = $clog2(FFT_MEM_SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_i,
  input  logic [ADDR_WDT-1:0] rd_addr_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic                last_o
);

  localparam logic [ADDR_WDT-1:0] LAST_ADDR = ADDR_WDT'(FFT_MEM_SIZE - 1);

  logic valid_q;
  logic last_q;

  // A new issue always refills the stage; otherwise it empties on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (issue_i) begin
      valid_q <= 1'b1;
      last_q  <= (rd_addr_i == LAST_ADDR);
    end else if (ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for an in-place FFT core: load a frame, trigger compute, stream results out.
// state   | meaning
// IDLE    | one cycle after reset
// LOAD    | accepting input samples into memory
// COMPUTE | waiting for fft_done from the core
// UNLOAD  | reading results out over the output stream
module fft_frame_ctrl
  import fft_ctrl_pckg::*;
#(
  parameter int unsigned FFT_MEM_SIZE = FFT_MEM_SIZE_DFLT,
  parameter int unsigned ADDR_WDT     = $clog2(FFT_MEM_SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic                mem_wr_en,
  output logic [ADDR_WDT-1:0] mem_wr_addr,
  output logic                fft_start,
  input  logic                fft_done,
  output logic                mem_rd_en,
  output logic [ADDR_WDT-1:0] mem_rd_addr,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                busy,
  output logic                err_tlast,
  input  logic                clr_err,
  output logic [15:0]         frame_cnt
);

  localparam logic [ADDR_WDT-1:0] LAST_ADDR = ADDR_WDT'(FFT_MEM_SIZE - 1);
  localparam logic [ADDR_WDT:0]   RD_END    = (ADDR_WDT + 1)'(FFT_MEM_SIZE);

  fft_ctrl_state_t     state_q;
  logic [ADDR_WDT-1:0] wr_cnt_q;
  logic [ADDR_WDT:0]   rd_cnt_q;
  logic                fft_start_q;
  logic                err_q;
  logic [15:0]         frame_cnt_q;

  logic wr_hs;
  logic wr_final;
  logic rd_issue;
  logic frame_end;

  assign s_axis_tready = (state_q == LOAD);
  assign wr_hs         = s_axis_tvalid && s_axis_tready;
  assign wr_final      = wr_hs && (wr_cnt_q == LAST_ADDR);
  assign mem_wr_en     = wr_hs;
  assign mem_wr_addr   = wr_cnt_q;

  // rd_cnt is one bit wider so it can sit at FFT_MEM_SIZE once every read is issued.
  assign rd_issue    = (state_q == UNLOAD) && (rd_cnt_q < RD_END) &&
                       (!m_axis_tvalid || m_axis_tready);
  assign mem_rd_en   = rd_issue;
  assign mem_rd_addr = rd_cnt_q[ADDR_WDT-1:0];
  assign frame_end   = (state_q == UNLOAD) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      fft_start_q <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      fft_start_q <= 1'b0;
      if (clr_err) err_q <= 1'b0;
      case (state_q)
        IDLE: state_q <= LOAD;
        LOAD: begin
          if (wr_final) begin
            state_q     <= COMPUTE;
            fft_start_q <= 1'b1;
            wr_cnt_q    <= '0;
            if (!s_axis_tlast) err_q <= 1'b1;
          end else if (wr_hs && s_axis_tlast) begin
            err_q    <= 1'b1;
            wr_cnt_q <= '0;
          end else if (wr_hs) begin
            wr_cnt_q <= wr_cnt_q + ADDR_WDT'(1);
          end
        end
        COMPUTE: begin
          if (fft_done) begin
            state_q  <= UNLOAD;
            rd_cnt_q <= '0;
          end
        end
        UNLOAD: begin
          if (rd_issue) rd_cnt_q <= rd_cnt_q + (ADDR_WDT + 1)'(1);
          if (frame_end) begin
            state_q     <= LOAD;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fft_rd_stage #(
    .FFT_MEM_SIZE (FFT_MEM_SIZE),
    .ADDR_WDT     (ADDR_WDT)
  ) u_rd_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_i   (rd_issue),
    .rd_addr_i (rd_cnt_q[ADDR_WDT-1:0]),
    .ready_i   (m_axis_tready),
    .valid_o   (m_axis_tvalid),
    .last_o    (m_axis_tlast)
  );

  assign fft_start = fft_start_q;
  assign busy      = (state_q != IDLE);
  assign err_tlast = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with the default 1024-sample frame.
module tb_fft_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic       mem_wr_en, mem_rd_en, fft_start, fft_done;
  logic [9:0] mem_wr_addr, mem_rd_addr;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic       busy, err_tlast, clr_err;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  fft_frame_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .fft_start     (fft_start),
    .fft_done      (fft_done),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .err_tlast     (err_tlast),
    .clr_err       (clr_err),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives n back-to-back beats; returns how many produced a correct write strobe/address.
  task automatic load(input int n, input int last_at, input int done_at, input int clr_at,
                      output int ok);
    ok = 0;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == last_at);
      fft_done      = (i == done_at);
      clr_err       = (i == clr_at);
      #1;
      if (s_axis_tready && mem_wr_en && mem_wr_addr == i[9:0]) ok++;
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    fft_done      = 1'b0;
    clr_err       = 1'b0;
  endtask

  // Holds COMPUTE ~50 cycles with input valid asserted, then pulses fft_done.
  task automatic compute(output int bad);
    bad = 0;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 49; c++) begin
      tick();
      if (fft_start || mem_wr_en || mem_rd_en || s_axis_tready || !busy) bad++;
    end
    s_axis_tvalid = 1'b0;
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
  endtask

  task automatic unload(input int pat, input int stop, output int beats, output int addr_ok,
                        output int last_bad, output int drops, output int span,
                        output bit finished);
    int  issued, first;
    bit  pend, hs;
    beats = 0; addr_ok = 0; last_bad = 0; drops = 0; span = -1; finished = 0;
    issued = 0; first = 0; pend = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      m_axis_tready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      #1;
      if (mem_rd_en) begin
        if (issued < 1024 && mem_rd_addr == issued[9:0]) addr_ok++;
        issued++;
      end
      if (pend && !m_axis_tvalid) drops++;
      hs   = m_axis_tvalid && m_axis_tready;
      pend = m_axis_tvalid && !m_axis_tready;
      if (hs) begin
        if (m_axis_tlast !== (beats == 1023)) last_bad++;
        if (beats == 0) first = cyc;
        beats++;
        if (m_axis_tlast) begin
          span = cyc - first;
          finished = 1;
          tick();
          break;
        end
        if (beats == stop) begin
          finished = 1;
          break;
        end
      end
      tick();
    end
    m_axis_tready = 1'b1;
  endtask

  initial begin
    int ok, bad, beats, addr_ok, last_bad, drops, span;
    bit fin;

    rst_n = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; fft_done = 1'b1;
    m_axis_tready = 1'b1; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_fft_start", fft_start, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_tlast, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; fft_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_to_load_tready", s_axis_tready, 1);
    chk("idle_to_load_busy", busy, 1);

    // Spurious done at the start of LOAD and again mid-frame.
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("spur_done_state", s_axis_tready, 1);
    chk("spur_done_start", fft_start, 0);

    // Nominal frame.
    load(1024, 1023, 300, -1, ok);
    chk("nom_wr_addrs", ok, 1024);
    chk("nom_fft_start", fft_start, 1);
    chk("nom_compute_tready", s_axis_tready, 0);
    chk("nom_err", err_tlast, 0);
    compute(bad);
    chk("nom_compute_quiet", bad, 0);
    unload(0, 0, beats, addr_ok, last_bad, drops, span, fin);
    chk("nom_unload_done", fin, 1);
    chk("nom_beats", beats, 1024);
    chk("nom_rd_addrs", addr_ok, 1024);
    chk("nom_tlast", last_bad, 0);
    chk("nom_span", span, 1023);
    chk("nom_frame_cnt", frame_cnt, 1);
    chk("nom_back_to_load", s_axis_tready, 1);
    chk("nom_tvalid_idle", m_axis_tvalid, 0);

    // Backpressure frame.
    load(1024, 1023, -1, -1, ok);
    chk("bp_wr_addrs", ok, 1024);
    compute(bad);
    chk("bp_compute_quiet", bad, 0);
    unload(1, 0, beats, addr_ok, last_bad, drops, span, fin);
    chk("bp_unload_done", fin, 1);
    chk("bp_beats", beats, 1024);
    chk("bp_rd_addrs", addr_ok, 1024);
    chk("bp_tlast", last_bad, 0);
    chk("bp_no_drop", drops, 0);
    chk("bp_frame_cnt", frame_cnt, 2);

    // Early tlast on beat 10, clear, then clear racing a new error.
    load(11, 10, -1, -1, ok);
    chk("early_wr_addrs", ok, 11);
    chk("early_err", err_tlast, 1);
    chk("early_stay_load", s_axis_tready, 1);
    chk("early_no_start", fft_start, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err", err_tlast, 0);
    load(4, 3, -1, 3, ok);
    chk("err_wins_addrs", ok, 4);
    chk("err_wins_clr", err_tlast, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err2", err_tlast, 0);

    // Full frame with no tlast at all: flagged, but still computes.
    load(1024, -1, -1, -1, ok);
    chk("miss_wr_addrs", ok, 1024);
    chk("miss_err", err_tlast, 1);
    chk("miss_fft_start", fft_start, 1);
    compute(bad);
    unload(0, 0, beats, addr_ok, last_bad, drops, span, fin);
    chk("miss_beats", beats, 1024);
    chk("miss_frame_cnt", frame_cnt, 3);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Reset at UNLOAD beat 500 with a pending fft_done across release.
    load(1024, 1023, -1, -1, ok);
    compute(bad);
    unload(0, 500, beats, addr_ok, last_bad, drops, span, fin);
    chk("mid_unload_beats", beats, 500);
    rst_n = 1'b0;
    fft_done = 1'b1;
    #1;
    chk("mid_rst_m_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_m_tlast", m_axis_tlast, 0);
    chk("mid_rst_rd_en", mem_rd_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_tready", s_axis_tready, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    fft_done = 1'b0;
    chk("post_rst_load", s_axis_tready, 1);
    load(1024, 1023, -1, -1, ok);
    chk("post_rst_wr_addrs", ok, 1024);
    compute(bad);
    unload(0, 0, beats, addr_ok, last_bad, drops, span, fin);
    chk("post_rst_beats", beats, 1024);
    chk("post_rst_frame_cnt", frame_cnt, 1);

    // Frame counter wrap.
    load(1024, 1023, -1, -1, ok);
    compute(bad);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    @(negedge clk);
    chk("wrap_preload", frame_cnt, 32'hFFFF);
    unload(0, 0, beats, addr_ok, last_bad, drops, span, fin);
    chk("wrap_beats", beats, 1024);
    chk("wrap_frame_cnt", frame_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
